// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and big-endian byte-enable patterns for data-memory access
package mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} accState;
   localparam logic [3:0] BE_BYTE    = 4'b1000;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_WORD    = 4'b1111;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: big-endian lane steering for stores and lane extraction/extension for loads
module dmem_align
   import mem_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic        isHalf,
   input  logic        isByte,
   input  logic        signExt,
   input  logic [31:0] storeData,
   input  logic [31:0] readWord,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] loadData
);
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   // offset 0 is the most significant lane, so a byte sits (3-offset) lanes up from bit 0
   always_comb begin
      laneByte = 8'(readWord >> {~offset, 3'b000});
      laneHalf = offset[1] ? readWord[15:0] : readWord[31:16];
      be       = isByte ? BE_BYTE >> offset : isHalf ? (offset[1] ? BE_HALF_LO : BE_HALF_HI) : BE_WORD;
      wdata    = isByte ? {4{storeData[7:0]}} : isHalf ? {2{storeData[15:0]}} : storeData;
      loadData = isByte ? {{24{signExt & laneByte[7]}}, laneByte}
               : isHalf ? {{16{signExt & laneHalf[15]}}, laneHalf} : readWord;
   end
endmodule

// File: rtl/dmem_access.sv
// dmem_access: MEM-stage load/store unit with stall handshake, alignment checks and LL/SC link
module dmem_access
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              MemHalf,
   input  logic              MemByte,
   input  logic              MemSignExtend,
   input  logic              LLSC,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] MemReadData,
   output logic              StallController,
   output logic              AddrError,
   output logic              ScResult,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata
);
   accState state, next;
   logic [ADDR_W-3:0] addrQ, linkAddr;
   logic [3:0]        beQ, beS;
   logic [DATA_W-1:0] wdataQ, wdataS, loadData;
   logic [1:0]        offQ;
   logic              weQ, readQ, halfQ, byteQ, sextQ, llQ, scOkQ, flushQ, linkValid;
   logic              idle, isMem, isSc, misaligned, scFail, access, discard;

   assign idle       = state == IDLE;
   assign isMem      = MemRead | MemWrite;
   assign isSc       = MemWrite & LLSC;
   assign misaligned = (MemHalf & ALUResult[0]) | (~MemHalf & ~MemByte & |ALUResult[1:0]);
   assign scFail     = isSc & ~(linkValid & linkAddr == ALUResult[ADDR_W-1:2]);
   assign access     = idle & isMem & ~Flush & ~misaligned & ~scFail;
   assign discard    = Flush | flushQ;
   assign dm_addr    = {addrQ, 2'b00};
   assign dm_be      = beQ;
   assign dm_wdata   = wdataQ;

   // live command steers the lanes while idle; the latched command formats the returning word
   dmem_align uAlign (
      .offset   (idle ? ALUResult[1:0] : offQ),
      .isHalf   (idle ? MemHalf : halfQ),
      .isByte   (idle ? MemByte : byteQ),
      .signExt  (idle ? MemSignExtend : sextQ),
      .storeData(ReadData2),
      .readWord (dm_rdata),
      .be       (beS),
      .wdata    (wdataS),
      .loadData (loadData)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   // next state: a flushed bus cycle skips DONE so the discarded result is never presented
   always_comb begin
      next = idle ? (access ? BUSY : IDLE)
           : state == BUSY ? (dm_ack ? (discard ? IDLE : DONE) : BUSY)
           : (state == DONE && Stall && !Flush) ? DONE : IDLE;
   end

   // outputs decoded from state and the current command
   always_comb begin
      StallController = access | state == BUSY;
      dm_req          = state == BUSY;
      dm_we           = state == BUSY & weQ;
      AddrError       = idle & isMem & misaligned;
      ScResult        = state == DONE & scOkQ;
   end

   // command latch, load result and LL link tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         addrQ <= '0; beQ <= '0; wdataQ <= '0; offQ <= '0;
         weQ <= 1'b0; readQ <= 1'b0; halfQ <= 1'b0; byteQ <= 1'b0; sextQ <= 1'b0;
         llQ <= 1'b0; scOkQ <= 1'b0; flushQ <= 1'b0;
         MemReadData <= '0; linkValid <= 1'b0; linkAddr <= '0;
      end else begin
         if (access) begin
            addrQ  <= ALUResult[ADDR_W-1:2];
            beQ    <= beS;
            wdataQ <= wdataS;
            offQ   <= ALUResult[1:0];
            weQ    <= MemWrite;
            readQ  <= MemRead;
            halfQ  <= MemHalf;
            byteQ  <= MemByte;
            sextQ  <= MemSignExtend;
            llQ    <= MemRead & LLSC;
            scOkQ  <= isSc;
            flushQ <= 1'b0;
         end else if (state == BUSY && Flush) flushQ <= 1'b1;
         if (state == BUSY && dm_ack && !discard && readQ) MemReadData <= loadData;
         if (Flush || (idle && isSc)) linkValid <= 1'b0;
         else if (state == BUSY && dm_ack && llQ && !flushQ) begin
            linkValid <= 1'b1;
            linkAddr  <= addrQ;
         end
      end
   end
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed scenario checks for the data-memory access unit
module tb_dmem_access;
   logic        clk = 1'b0, rst = 1'b1;
   logic        Stall = 0, Flush = 0, MemRead = 0, MemWrite = 0, MemHalf = 0, MemByte = 0;
   logic        MemSignExtend = 0, LLSC = 0, dm_ack = 0;
   logic [31:0] ALUResult = 0, ReadData2 = 0, dm_rdata = 0;
   logic [31:0] MemReadData, dm_addr, dm_wdata;
   logic        StallController, AddrError, ScResult, dm_req, dm_we;
   logic [3:0]  dm_be;
   int          checks = 0, errors = 0;

   dmem_access dut (
      .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemHalf(MemHalf), .MemByte(MemByte), .MemSignExtend(MemSignExtend), .LLSC(LLSC),
      .ALUResult(ALUResult), .ReadData2(ReadData2), .MemReadData(MemReadData),
      .StallController(StallController), .AddrError(AddrError), .ScResult(ScResult),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn;
      MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0; MemSignExtend = 0; LLSC = 0;
      ALUResult = 0; ReadData2 = 0;
   endtask

   task automatic runAccess(input int n, input logic [31:0] rdata);
      tick;
      repeat (n - 1) tick;
      dm_rdata = rdata; dm_ack = 1;
      tick;
      dm_ack = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      tick; tick;
      rst = 0;
      checks++; if (MemReadData !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", MemReadData); end
      checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dm_req); end
      checks++; if (StallController !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", StallController); end
      checks++; if (ScResult !== 1'b0) begin errors++; $display("FAIL reset_sc got %b want 0", ScResult); end
   endtask

   task automatic test_lw;
      int cnt = 0;
      MemRead = 1; ALUResult = 32'h100;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (StallController) cnt++;
         if (i == 1) begin
            checks++; if (dm_req !== 1'b1 || dm_addr !== 32'h100 || dm_be !== 4'b1111 || dm_we !== 1'b0) begin
               errors++; $display("FAIL lw_bus got req=%b addr=%h be=%b we=%b want 1 100 1111 0", dm_req, dm_addr, dm_be, dm_we); end
         end
         if (i == 3) begin dm_rdata = 32'h11223344; dm_ack = 1; end
         tick;
      end
      dm_ack = 0;
      checks++; if (cnt !== 4) begin errors++; $display("FAIL lw_stall_cycles got %0d want 4", cnt); end
      checks++; if (StallController !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL lw_done got stall=%b req=%b want 0 0", StallController, dm_req); end
      checks++; if (MemReadData !== 32'h11223344) begin errors++; $display("FAIL lw_data got %h want 11223344", MemReadData); end
      clearIn;
      tick;
      MemRead = 1; ALUResult = 32'h104;
      #1;
      checks++; if (StallController !== 1'b1) begin errors++; $display("FAIL lw_done_one_cycle got stall=%b want 1", StallController); end
      runAccess(1, 32'hCAFEF00D);
      checks++; if (MemReadData !== 32'hCAFEF00D) begin errors++; $display("FAIL lw2_data got %h want cafef00d", MemReadData); end
      clearIn;
      tick;
   endtask

   task automatic test_load_format;
      MemRead = 1; MemByte = 1; MemSignExtend = 1; ALUResult = 32'h103;
      runAccess(2, 32'h000000F0);
      checks++; if (MemReadData !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_signed got %h want fffffff0", MemReadData); end
      Stall = 1;
      tick; tick;
      checks++; if (StallController !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL done_hold got stall=%b req=%b want 0 0", StallController, dm_req); end
      Stall = 0; clearIn;
      tick;
      MemRead = 1; MemByte = 1; ALUResult = 32'h103;
      runAccess(1, 32'h000000F0);
      checks++; if (MemReadData !== 32'h000000F0) begin errors++; $display("FAIL lbu got %h want 000000f0", MemReadData); end
      clearIn;
      tick;
      MemRead = 1; MemHalf = 1; MemSignExtend = 1; ALUResult = 32'h002;
      runAccess(1, 32'h12348765);
      checks++; if (MemReadData !== 32'hFFFF8765) begin errors++; $display("FAIL lh_signed got %h want ffff8765", MemReadData); end
      clearIn;
      tick;
      MemRead = 1; MemByte = 1; ALUResult = 32'h100;
      runAccess(1, 32'hA5000000);
      checks++; if (MemReadData !== 32'h000000A5) begin errors++; $display("FAIL lbu_off0 got %h want 000000a5", MemReadData); end
      clearIn;
      tick;
   endtask

   task automatic test_store;
      MemWrite = 1; MemHalf = 1; ALUResult = 32'h202; ReadData2 = 32'h0000ABCD;
      #1;
      checks++; if (StallController !== 1'b1) begin errors++; $display("FAIL sh_stall got %b want 1", StallController); end
      tick;
      checks++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_be !== 4'b0011 || dm_wdata !== 32'hABCDABCD || dm_addr !== 32'h200) begin
         errors++; $display("FAIL sh_bus got req=%b we=%b be=%b wdata=%h addr=%h want 1 1 0011 abcdabcd 200", dm_req, dm_we, dm_be, dm_wdata, dm_addr); end
      ALUResult = 32'h0; ReadData2 = 32'h0;
      tick;
      checks++; if (dm_be !== 4'b0011 || dm_wdata !== 32'hABCDABCD || dm_addr !== 32'h200) begin
         errors++; $display("FAIL sh_hold got be=%b wdata=%h addr=%h want 0011 abcdabcd 200", dm_be, dm_wdata, dm_addr); end
      dm_ack = 1;
      tick;
      dm_ack = 0;
      checks++; if (MemReadData !== 32'h000000A5) begin errors++; $display("FAIL sh_rdata_kept got %h want 000000a5", MemReadData); end
      clearIn;
      tick;
      MemWrite = 1; MemByte = 1; ALUResult = 32'h101; ReadData2 = 32'h1234565A;
      tick;
      checks++; if (dm_be !== 4'b0100 || dm_wdata !== 32'h5A5A5A5A || dm_addr !== 32'h100) begin
         errors++; $display("FAIL sb_bus got be=%b wdata=%h addr=%h want 0100 5a5a5a5a 100", dm_be, dm_wdata, dm_addr); end
      dm_ack = 1;
      tick;
      dm_ack = 0; clearIn;
      tick;
   endtask

   task automatic test_misaligned;
      MemRead = 1; ALUResult = 32'h101;
      #1;
      checks++; if (AddrError !== 1'b1 || StallController !== 1'b0) begin errors++; $display("FAIL lw_mis got err=%b stall=%b want 1 0", AddrError, StallController); end
      tick;
      checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL lw_mis_req got %b want 0", dm_req); end
      MemRead = 0; MemWrite = 1; MemHalf = 1; ALUResult = 32'h203;
      #1;
      checks++; if (AddrError !== 1'b1 || StallController !== 1'b0) begin errors++; $display("FAIL sh_mis got err=%b stall=%b want 1 0", AddrError, StallController); end
      clearIn;
      #1;
      checks++; if (AddrError !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", AddrError); end
      tick;
   endtask

   task automatic test_llsc;
      MemRead = 1; LLSC = 1; ALUResult = 32'h300;
      runAccess(1, 32'h55667788);
      checks++; if (MemReadData !== 32'h55667788 || ScResult !== 1'b0) begin errors++; $display("FAIL ll got data=%h sc=%b want 55667788 0", MemReadData, ScResult); end
      clearIn;
      tick;
      MemWrite = 1; LLSC = 1; ALUResult = 32'h300; ReadData2 = 32'hDEADBEEF;
      #1;
      checks++; if (StallController !== 1'b1) begin errors++; $display("FAIL sc_ok_stall got %b want 1", StallController); end
      tick;
      checks++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || ScResult !== 1'b0) begin errors++; $display("FAIL sc_ok_bus got req=%b we=%b sc=%b want 1 1 0", dm_req, dm_we, ScResult); end
      dm_ack = 1;
      tick;
      dm_ack = 0;
      checks++; if (ScResult !== 1'b1) begin errors++; $display("FAIL sc_ok_result got %b want 1", ScResult); end
      clearIn;
      tick;
      MemWrite = 1; LLSC = 1; ALUResult = 32'h300;
      #1;
      checks++; if (StallController !== 1'b0 || ScResult !== 1'b0) begin errors++; $display("FAIL sc_repeat got stall=%b sc=%b want 0 0", StallController, ScResult); end
      tick;
      checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL sc_repeat_req got %b want 0", dm_req); end
      clearIn;
      MemRead = 1; LLSC = 1; ALUResult = 32'h300;
      runAccess(1, 32'h0BADF00D);
      clearIn;
      tick;
      MemWrite = 1; LLSC = 1; ALUResult = 32'h304;
      #1;
      checks++; if (StallController !== 1'b0) begin errors++; $display("FAIL sc_mismatch got stall=%b want 0", StallController); end
      tick;
      ALUResult = 32'h300;
      #1;
      checks++; if (StallController !== 1'b0) begin errors++; $display("FAIL sc_after_fail got stall=%b want 0", StallController); end
      clearIn;
      tick;
   endtask

   task automatic test_flush;
      MemRead = 1; ALUResult = 32'h400;
      tick;
      Flush = 1;
      #1;
      checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL flush_req got %b want 1", dm_req); end
      tick;
      Flush = 0;
      checks++; if (dm_req !== 1'b1 || dm_addr !== 32'h400) begin errors++; $display("FAIL flush_hold got req=%b addr=%h want 1 400", dm_req, dm_addr); end
      dm_rdata = 32'h99999999; dm_ack = 1;
      tick;
      dm_ack = 0;
      checks++; if (MemReadData !== 32'h0BADF00D) begin errors++; $display("FAIL flush_data got %h want 0badf00d", MemReadData); end
      checks++; if (StallController !== 1'b1) begin errors++; $display("FAIL flush_idle got stall=%b want 1", StallController); end
      runAccess(1, 32'h77777777);
      checks++; if (MemReadData !== 32'h77777777) begin errors++; $display("FAIL post_flush_data got %h want 77777777", MemReadData); end
      clearIn;
      tick;
      MemRead = 1; LLSC = 1; ALUResult = 32'h500;
      tick;
      Flush = 1; dm_rdata = 32'h12121212; dm_ack = 1;
      tick;
      Flush = 0; dm_ack = 0; clearIn;
      checks++; if (MemReadData !== 32'h77777777 || dm_req !== 1'b0) begin errors++; $display("FAIL flush_ll got data=%h req=%b want 77777777 0", MemReadData, dm_req); end
      MemWrite = 1; LLSC = 1; ALUResult = 32'h500;
      #1;
      checks++; if (StallController !== 1'b0) begin errors++; $display("FAIL flush_ll_sc got stall=%b want 0", StallController); end
      clearIn;
      tick;
      MemRead = 1; LLSC = 1; ALUResult = 32'h600;
      runAccess(1, 32'h0);
      clearIn;
      tick;
      Flush = 1;
      tick;
      Flush = 0;
      MemWrite = 1; LLSC = 1; ALUResult = 32'h600;
      #1;
      checks++; if (StallController !== 1'b0) begin errors++; $display("FAIL flush_link_sc got stall=%b want 0", StallController); end
      clearIn;
      tick;
   endtask

   task automatic test_reset_busy;
      MemRead = 1; ALUResult = 32'h700;
      tick;
      checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req got %b want 1", dm_req); end
      rst = 1;
      tick;
      rst = 0;
      checks++; if (dm_req !== 1'b0 || MemReadData !== 32'h0) begin errors++; $display("FAIL rst_busy got req=%b data=%h want 0 0", dm_req, MemReadData); end
      clearIn;
      tick;
   endtask

   initial begin
      test_reset;
      test_lw;
      test_load_format;
      test_store;
      test_misaligned;
      test_llsc;
      test_flush;
      test_reset_busy;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
